// File: rtl/vga_sync_decoder_if.sv
// Sync-decoder signal bundle: raw sync inputs from the video source and the
// recovered timing outputs. master = sync source side, slave = decoder.
interface vga_sync_decoder_if;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        display_on;
    logic        locked;
    logic        frame_start;
    logic        sync_err;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;

    modport master (
        output hsync_in, vsync_in,
        input  hpos, vpos, display_on, locked, frame_start, sync_err,
               line_len, frame_lines
    );

    modport slave (
        input  hsync_in, vsync_in,
        output hpos, vpos, display_on, locked, frame_start, sync_err,
               line_len, frame_lines
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: measures hsync period and frame height from a sync
// generator on the same clock, locks after LOCK_FRAMES consecutive good frames
// and regenerates hpos/vpos/display_on cycle-aligned with the generator.
// Optional build macro VGA_SYNC_DECODER_POLARITY_EN adds per-input polarity
// detection (high vs low time per period) so negative-polarity sync is accepted.
module vga_sync_decoder #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_BOTTOM    = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_TOP       = 33,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                clk,
    input  logic                reset,
    vga_sync_decoder_if.slave   vif
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int unsigned H_ALIGN = H_DISPLAY + H_FRONT + 2;

    localparam logic [9:0]  H_ALIGN_V  = 10'(H_ALIGN);
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_DISP_V   = 10'(H_DISPLAY);
    localparam logic [9:0]  V_DISP_V   = 10'(V_DISPLAY);
    localparam logic [10:0] H_TOTAL_V  = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOTAL_V  = 10'(V_TOTAL);
    localparam logic [10:0] TIMEOUT_M1 = 11'(2 * H_TOTAL - 1);
    localparam logic [8:0]  LOCK_V     = 9'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ARMED, LOCKED} state_t;

    state_t      state;
    logic        hs, vs;
    logic        hs_d, vs_d;
    logic        hs_rise, vs_rise;
    logic [10:0] hcnt;
    logic [9:0]  lines;
    logic [9:0]  hpos, vpos;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic        frame_start;
    logic        sync_err;
    logic        locked;
    logic [7:0]  match;
    logic        bad_line;
    logic        skip_line;

    logic [10:0] line_meas;
    logic [9:0]  frame_lines_new;
    logic        line_bad_now;
    logic        frame_bad;
    logic        timeout;

`ifdef VGA_SYNC_DECODER_POLARITY_EN
    logic        hpol, vpol;
    logic [10:0] h_hi, h_lo;
    logic [19:0] v_hi, v_lo;
    logic        hpol_meas, vpol_meas;
    logic        pol_change;

    assign hs         = vif.hsync_in ^ hpol;
    assign vs         = vif.vsync_in ^ vpol;
    assign hpol_meas  = h_hi > h_lo;
    assign vpol_meas  = v_hi > v_lo;
    // Periods are delimited by rises of the corrected signal; a wrong guess
    // still yields a periodic edge, so the measurement converges in one period.
    assign pol_change = (hs_rise && (hpol_meas != hpol)) ||
                        (vs_rise && (vpol_meas != vpol));

    // High/low time accumulation per hsync period and per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpol <= 1'b0;
            vpol <= 1'b0;
            h_hi <= '0;
            h_lo <= '0;
            v_hi <= '0;
            v_lo <= '0;
        end else begin
            if (hs_rise) begin
                hpol <= hpol_meas;
                h_hi <= {10'b0, vif.hsync_in};
                h_lo <= {10'b0, ~vif.hsync_in};
            end else if (vif.hsync_in) begin
                if (h_hi != '1) h_hi <= h_hi + 11'd1;
            end else begin
                if (h_lo != '1) h_lo <= h_lo + 11'd1;
            end
            if (vs_rise) begin
                vpol <= vpol_meas;
                v_hi <= {19'b0, vif.vsync_in};
                v_lo <= {19'b0, ~vif.vsync_in};
            end else if (vif.vsync_in) begin
                if (v_hi != '1) v_hi <= v_hi + 20'd1;
            end else begin
                if (v_lo != '1) v_lo <= v_lo + 20'd1;
            end
        end
    end
`else
    assign hs = vif.hsync_in;
    assign vs = vif.vsync_in;
`endif

    assign hs_rise = hs & ~hs_d;
    assign vs_rise = vs & ~vs_d;

    // Measurement results for the current cycle, consumed by the FSM.
    always_comb begin
        line_meas       = (hcnt == '1) ? hcnt : hcnt + 11'd1;
        frame_lines_new = lines + {9'b0, hs_rise};
        line_bad_now    = hs_rise && !skip_line && (line_meas != H_TOTAL_V);
        frame_bad       = bad_line || line_bad_now || (frame_lines_new != V_TOTAL_V);
        timeout         = !hs_rise && (hcnt == TIMEOUT_M1);
    end

    // Edge-detect history keeps sampling through reset so that a sync level
    // already high when reset releases is not mistaken for a rise.
    always_ff @(posedge clk) begin
        hs_d <= hs;
        vs_d <= vs;
    end

    // Position regeneration and line/frame measurement.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos        <= '0;
            vpos        <= '0;
            hcnt        <= '0;
            lines       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= vs_rise;
            if (hs_rise) begin
                hpos     <= H_ALIGN_V;
                line_len <= line_meas;
                hcnt     <= '0;
            end else begin
                if (hcnt != '1) hcnt <= hcnt + 11'd1;
                if (hpos == H_LAST) begin
                    hpos <= '0;
                    vpos <= (vpos == V_LAST) ? '0 : vpos + 10'd1;
                end else begin
                    hpos <= hpos + 10'd1;
                end
            end
            if (vs_rise) begin
                vpos        <= '0;
                frame_lines <= frame_lines_new;
                lines       <= '0;
            end else if (hs_rise) begin
                lines <= lines + 10'd1;
            end
        end
    end

    // Lock FSM: arm on first vsync, count good frames, drop on error/timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            match     <= '0;
            bad_line  <= 1'b0;
            skip_line <= 1'b0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            case (state)
                SEARCH: begin
                    if (vs_rise) begin
                        state     <= ARMED;
                        match     <= '0;
                        bad_line  <= 1'b0;
                        skip_line <= 1'b1;
                    end
                end
                default: begin
                    if (hs_rise) skip_line <= 1'b0;
                    if (timeout) begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                    end else if (vs_rise) begin
                        bad_line <= 1'b0;
                        if (!frame_bad) begin
                            if (match != '1) match <= match + 8'd1;
                            if (({1'b0, match} + 9'd1) >= LOCK_V) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match    <= '0;
                            sync_err <= 1'b1;
                            state    <= ARMED;
                            locked   <= 1'b0;
                        end
                    end else if (line_bad_now) begin
                        bad_line <= 1'b1;
                    end
                end
            endcase
`ifdef VGA_SYNC_DECODER_POLARITY_EN
            if (pol_change) begin
                state    <= SEARCH;
                locked   <= 1'b0;
                match    <= '0;
                sync_err <= 1'b0;
            end
`endif
        end
    end

    assign vif.hpos        = hpos;
    assign vif.vpos        = vpos;
    assign vif.display_on  = (hpos < H_DISP_V) && (vpos < V_DISP_V) && locked;
    assign vif.locked      = locked;
    assign vif.frame_start = frame_start;
    assign vif.sync_err    = sync_err;
    assign vif.line_len    = line_len;
    assign vif.frame_lines = frame_lines;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a small-timing sync generator model drives the
// decoder; directed scenarios check lock, errors, timeout and mid-frame reset.
module tb_vga_sync_decoder;

    localparam int H_DISPLAY = 16;
    localparam int H_FRONT   = 4;
    localparam int H_SYNC    = 6;
    localparam int H_BACK    = 6;
    localparam int V_DISPLAY = 10;
    localparam int V_BOTTOM  = 2;
    localparam int V_SYNC    = 2;
    localparam int V_TOP     = 3;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;  // 32
    localparam int V_TOTAL   = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;  // 17
    localparam int HS_START  = H_DISPLAY + H_FRONT + 1;               // 21
    localparam int HS_END    = H_DISPLAY + H_FRONT + H_SYNC;          // 26

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_sync_decoder_if vif ();

    vga_sync_decoder #(
        .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_DISPLAY(V_DISPLAY), .V_BOTTOM(V_BOTTOM), .V_SYNC(V_SYNC), .V_TOP(V_TOP),
        .LOCK_FRAMES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vif   (vif)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Generator model state.
    int gh = 0;
    int gv = 0;
    bit force_low   = 1'b0;
    bit stretch_req = 1'b0;
    int stretch_line = 5;
    bit skip_req    = 1'b0;
    bit track       = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic drive();
        vif.hsync_in = !force_low && (gh >= HS_START) && (gh <= HS_END);
        vif.vsync_in = ((gv == V_TOTAL - 1) && (gh == H_TOTAL - 1)) || (gv < V_SYNC);
    endtask

    task automatic advance();
        if (stretch_req && gv == stretch_line && gh == 0) begin
            stretch_req = 1'b0;
        end else if (gh == H_TOTAL - 1) begin
            gh = 0;
            if (gv == V_TOTAL - 1) gv = 0;
            else if (skip_req && gv == V_TOTAL - 3) begin
                gv = V_TOTAL - 1;
                skip_req = 1'b0;
            end else gv = gv + 1;
        end else begin
            gh = gh + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        advance();
        drive();
        if (track) begin
            check("hpos", 32'(vif.hpos), 32'(gh));
            check("vpos", 32'(vif.vpos), 32'(gv));
            check("display_on", 32'(vif.display_on),
                  32'((gh < H_DISPLAY) && (gv < V_DISPLAY)));
        end
    endtask

    // Runs until the decoder has sampled the next generator vsync rise.
    task automatic to_vs_rise();
        int n = 0;
        while (!(gv == V_TOTAL - 1 && gh == H_TOTAL - 1) && n < 4 * V_TOTAL * H_TOTAL) begin
            step();
            n++;
        end
        if (n >= 4 * V_TOTAL * H_TOTAL) check("vs_wait_bound", 32'd1, 32'd0);
        step();
    endtask

    task automatic goto_pos(input int line, input int col);
        int n = 0;
        while (!(gv == line && gh == col) && n < 4 * V_TOTAL * H_TOTAL) begin
            step();
            n++;
        end
        if (n >= 4 * V_TOTAL * H_TOTAL) check("pos_wait_bound", 32'd1, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_cnt;
        int err_at;

        drive();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hpos", 32'(vif.hpos), 32'd0);
        check("rst_vpos", 32'(vif.vpos), 32'd0);
        check("rst_locked", 32'(vif.locked), 32'd0);
        check("rst_line_len", 32'(vif.line_len), 32'd0);
        check("rst_frame_lines", 32'(vif.frame_lines), 32'd0);
        check("rst_display_on", 32'(vif.display_on), 32'd0);
        reset = 1'b0;

        // Lock sequence: locked appears only after the third vsync rise.
        to_vs_rise();
        check("t1_frame_start", 32'(vif.frame_start), 32'd1);
        check("t1_frame_lines", 32'(vif.frame_lines), 32'(V_TOTAL));
        check("t1_line_len", 32'(vif.line_len), 32'(H_TOTAL));
        check("t1_locked_r1", 32'(vif.locked), 32'd0);
        check("t1_sync_err_r1", 32'(vif.sync_err), 32'd0);
        to_vs_rise();
        check("t1_locked_r2", 32'(vif.locked), 32'd0);
        check("t1_frame_lines_r2", 32'(vif.frame_lines), 32'(V_TOTAL));
        to_vs_rise();
        check("t1_locked_r3", 32'(vif.locked), 32'd1);

        // Full frame of cycle-by-cycle position tracking.
        track = 1'b1;
        to_vs_rise();
        check("t1_frame_start_r4", 32'(vif.frame_start), 32'd1);
        check("t1_locked_r4", 32'(vif.locked), 32'd1);
        check("t1_sync_err_r4", 32'(vif.sync_err), 32'd0);
        step();
        check("t1_frame_start_pulse", 32'(vif.frame_start), 32'd0);
        track = 1'b0;

        // One stretched line: error at next vsync, relock after two good frames.
        stretch_req = 1'b1;
        to_vs_rise();
        check("t2_sync_err", 32'(vif.sync_err), 32'd1);
        check("t2_locked", 32'(vif.locked), 32'd0);
        check("t2_frame_lines", 32'(vif.frame_lines), 32'(V_TOTAL));
        step();
        check("t2_sync_err_pulse", 32'(vif.sync_err), 32'd0);
        to_vs_rise();
        check("t2_locked_r1", 32'(vif.locked), 32'd0);
        to_vs_rise();
        check("t2_relocked", 32'(vif.locked), 32'd1);

        // Short frame (one line missing).
        skip_req = 1'b1;
        to_vs_rise();
        check("t5_frame_lines", 32'(vif.frame_lines), 32'(V_TOTAL - 1));
        check("t5_sync_err", 32'(vif.sync_err), 32'd1);
        check("t5_locked", 32'(vif.locked), 32'd0);
        to_vs_rise();
        check("t5_frame_lines_r1", 32'(vif.frame_lines), 32'(V_TOTAL));
        check("t5_locked_r1", 32'(vif.locked), 32'd0);
        to_vs_rise();
        check("t5_relocked", 32'(vif.locked), 32'd1);

        // hsync stuck low: timeout 2*H_TOTAL clocks after the last hsync rise.
        goto_pos(3, 0);
        force_low = 1'b1;
        drive();
        err_cnt = 0;
        err_at  = 0;
        for (int k = 1; k <= 3 * H_TOTAL; k++) begin
            step();
            if (vif.sync_err === 1'b1) begin
                err_cnt++;
                err_at = k;
            end
        end
        check("t3_err_count", 32'(err_cnt), 32'd1);
        check("t3_err_cycle", 32'(err_at), 32'(H_TOTAL + HS_START + 1));
        check("t3_locked", 32'(vif.locked), 32'd0);
        force_low = 1'b0;
        to_vs_rise();
        check("t3_locked_r1", 32'(vif.locked), 32'd0);
        check("t3_sync_err_r1", 32'(vif.sync_err), 32'd0);
        to_vs_rise();
        check("t3_locked_r2", 32'(vif.locked), 32'd0);
        to_vs_rise();
        check("t3_relocked", 32'(vif.locked), 32'd1);

        // One-cycle reset mid-frame.
        goto_pos(8, 10);
        check("t4_pre_hpos", 32'(vif.hpos), 32'd10);
        check("t4_pre_vpos", 32'(vif.vpos), 32'd8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t4_hpos", 32'(vif.hpos), 32'd0);
        check("t4_vpos", 32'(vif.vpos), 32'd0);
        check("t4_locked", 32'(vif.locked), 32'd0);
        check("t4_display_on", 32'(vif.display_on), 32'd0);
        check("t4_line_len", 32'(vif.line_len), 32'd0);
        check("t4_frame_lines", 32'(vif.frame_lines), 32'd0);
        check("t4_sync_err", 32'(vif.sync_err), 32'd0);
        check("t4_frame_start", 32'(vif.frame_start), 32'd0);
        to_vs_rise();
        check("t4_locked_r1", 32'(vif.locked), 32'd0);
        to_vs_rise();
        check("t4_locked_r2", 32'(vif.locked), 32'd0);
        to_vs_rise();
        check("t4_relocked", 32'(vif.locked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
